// File: rtl/ffe_pkg.sv
// Shared definitions for the FFE coefficient path: default dimensions,
// FSM state encoding and the coefficient rail codes.
package ffe_pkg;

  localparam int FFE_LEN = 21;  // number of taps
  localparam int NB      = 8;   // coefficient width, signed two's complement
  localparam int NBF     = 7;   // fractional bits (informational only)

  // Coefficient-bank FSM encoding, visible on o_state
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HOLD = 2'b01,
    ST_DIV  = 2'b10
  } state_t;

  // Rail codes for an NB-bit signed coefficient
  localparam logic [NB-1:0] COEFF_MAX = {1'b0, {(NB-1){1'b1}}};
  localparam logic [NB-1:0] COEFF_MIN = {1'b1, {(NB-1){1'b0}}};

endpackage

// File: rtl/coeff_sat_detect.sv
// Combinational "any tap sits on a rail" reduction over a flat coefficient
// vector. Rails are derived from NB so the block can be reused with other
// widths by the adaptation engine's monitors.
module coeff_sat_detect #(
  parameter int FFE_LEN = 21,
  parameter int NB      = 8
) (
  input  logic [FFE_LEN*NB-1:0] i_coeff_flat,
  output logic                  o_any_sat
);

  localparam logic [NB-1:0] RAIL_MAX = {1'b0, {(NB-1){1'b1}}};
  localparam logic [NB-1:0] RAIL_MIN = {1'b1, {(NB-1){1'b0}}};

  // OR together a per-tap rail match
  always_comb begin
    o_any_sat = 1'b0;
    for (int k = 0; k < FFE_LEN; k++) begin
      if ((i_coeff_flat[k*NB +: NB] == RAIL_MAX) ||
          (i_coeff_flat[k*NB +: NB] == RAIL_MIN)) begin
        o_any_sat = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ffe_coeff_bank.sv
// FFE coefficient register bank. Takes adaptation-engine updates, adds
// freeze/reinit control, a single-tap host port, a divergence guard that
// counts consecutive rail-hitting updates, and a saturating update counter.
//
// Host read handshake: i_host_rd is a single-cycle request with no ready
// (always accepted). Exactly one cycle later o_host_rvalid is high for one
// cycle and o_host_rdata holds the tap value as it was before the edge that
// sampled the request; out-of-range addresses return 0 with rvalid set.
module ffe_coeff_bank #(
  parameter int FFE_LEN     = ffe_pkg::FFE_LEN,
  parameter int NB          = ffe_pkg::NB,
  parameter int NB_ADDR     = 5,
  parameter int CENTER_TAP  = 10,
  parameter int INIT_CENTER = 64,
  parameter int SAT_LIMIT   = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [FFE_LEN*NB-1:0] i_new_coeff,
  input  logic                  i_update_en,
  input  logic                  i_freeze,
  input  logic                  i_reinit,
  input  logic                  i_host_wr,
  input  logic                  i_host_rd,
  input  logic [NB_ADDR-1:0]    i_host_addr,
  input  logic [NB-1:0]         i_host_wdata,
  output logic [NB-1:0]         o_host_rdata,
  output logic                  o_host_rvalid,
  output logic [FFE_LEN*NB-1:0] o_coeff_flat,
  output logic [1:0]            o_state,
  output logic                  o_diverged,
  output logic [31:0]           o_update_count
);

  import ffe_pkg::*;

  localparam int SCW = $clog2(SAT_LIMIT + 1);
  localparam logic [NB-1:0] INIT_TAP = NB'(INIT_CENTER);
  localparam logic [FFE_LEN*NB-1:0] INIT_VEC =
    {{((FFE_LEN-1)*NB){1'b0}}, INIT_TAP} << (CENTER_TAP*NB);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [FFE_LEN*NB-1:0]   r_coeff;
  logic [FFE_LEN*NB-1:0]   w_coeff_next;
  logic [SCW-1:0]          r_sat_cnt;
  logic [SCW-1:0]          w_sat_inc;
  logic [31:0]             r_count;
  logic                    r_diverged;
  logic [NB-1:0]           r_rdata;
  logic                    r_rvalid;
  logic [NB-1:0]           w_rd_tap;
  logic                    w_any_sat;
  logic                    w_accept;
  logic                    w_diverge;

  coeff_sat_detect #(
    .FFE_LEN (FFE_LEN),
    .NB      (NB)
  ) u_sat_detect (
    .i_coeff_flat (i_new_coeff),
    .o_any_sat    (w_any_sat)
  );

  // An update lands only in RUN with enable and no freeze; the SAT_LIMIT-th
  // consecutive rail update is turned into a divergence event instead.
  always_comb begin
    w_accept  = (r_state == ST_RUN) && i_enable && i_update_en && !i_freeze;
    w_sat_inc = r_sat_cnt + 1'b1;
    w_diverge = w_accept && w_any_sat && (w_sat_inc == SCW'(SAT_LIMIT));
  end

  // Next-state logic; reinit overrides every state
  always_comb begin
    w_state_next = r_state;
    if (i_reinit) begin
      w_state_next = i_freeze ? ST_HOLD : ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_diverge)     w_state_next = ST_DIV;
          else if (i_freeze) w_state_next = ST_HOLD;
        end
        ST_HOLD: begin
          if (!i_freeze) w_state_next = ST_RUN;
        end
        ST_DIV:  w_state_next = ST_DIV;
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  // Next coefficient vector: reinit > host write (one tap) > update/diverge
  always_comb begin
    w_coeff_next = r_coeff;
    if (i_reinit) begin
      w_coeff_next = INIT_VEC;
    end else begin
      if (w_diverge)     w_coeff_next = INIT_VEC;
      else if (w_accept) w_coeff_next = i_new_coeff;
      if (i_host_wr) begin
        for (int k = 0; k < FFE_LEN; k++) begin
          if (i_host_addr == NB_ADDR'(k)) w_coeff_next[k*NB +: NB] = i_host_wdata;
        end
      end
    end
  end

  // Host read mux over the pre-edge register contents; no match returns 0
  always_comb begin
    w_rd_tap = '0;
    for (int k = 0; k < FFE_LEN; k++) begin
      if (i_host_addr == NB_ADDR'(k)) w_rd_tap = r_coeff[k*NB +: NB];
    end
  end

  // State, coefficient bank and status registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_RUN;
      r_coeff    <= INIT_VEC;
      r_sat_cnt  <= '0;
      r_count    <= '0;
      r_diverged <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_coeff <= w_coeff_next;
      if (i_reinit) begin
        r_sat_cnt  <= '0;
        r_count    <= '0;
        r_diverged <= 1'b0;
      end else if (w_accept) begin
        r_sat_cnt <= w_any_sat ? w_sat_inc : '0;
        if (w_diverge) begin
          r_diverged <= 1'b1;
        end else if (r_count != 32'hFFFF_FFFF) begin
          r_count <= r_count + 32'd1;
        end
      end
    end
  end

  // Host read data/valid pipeline stage; reset cancels a pending pulse
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_host_rd;
      if (i_host_rd) r_rdata <= w_rd_tap;
    end
  end

  assign o_coeff_flat   = r_coeff;
  assign o_state        = r_state;
  assign o_diverged     = r_diverged;
  assign o_update_count = r_count;
  assign o_host_rdata   = r_rdata;
  assign o_host_rvalid  = r_rvalid;

endmodule

// File: tb/tb_ffe_coeff_bank.sv
// Directed bench for ffe_coeff_bank: direct checks of the vector/state/count
// after each scenario, plus an expected queue for host reads that a separate
// monitor drains whenever o_host_rvalid is seen.
module tb_ffe_coeff_bank;

  localparam int FFE_LEN = 21;
  localparam int NB      = 8;
  localparam int NB_ADDR = 5;
  localparam int VW      = FFE_LEN * NB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_reset;
  logic               i_enable;
  logic [VW-1:0]      i_new_coeff;
  logic               i_update_en;
  logic               i_freeze;
  logic               i_reinit;
  logic               i_host_wr;
  logic               i_host_rd;
  logic [NB_ADDR-1:0] i_host_addr;
  logic [NB-1:0]      i_host_wdata;
  logic [NB-1:0]      o_host_rdata;
  logic               o_host_rvalid;
  logic [VW-1:0]      o_coeff_flat;
  logic [1:0]         o_state;
  logic               o_diverged;
  logic [31:0]        o_update_count;

  ffe_coeff_bank dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_new_coeff    (i_new_coeff),
    .i_update_en    (i_update_en),
    .i_freeze       (i_freeze),
    .i_reinit       (i_reinit),
    .i_host_wr      (i_host_wr),
    .i_host_rd      (i_host_rd),
    .i_host_addr    (i_host_addr),
    .i_host_wdata   (i_host_wdata),
    .o_host_rdata   (o_host_rdata),
    .o_host_rvalid  (o_host_rvalid),
    .o_coeff_flat   (o_coeff_flat),
    .o_state        (o_state),
    .o_diverged     (o_diverged),
    .o_update_count (o_update_count)
  );

  int errors = 0;
  int checks = 0;
  logic [NB-1:0] exp_q[$];

  // ---------------- helpers ----------------
  function automatic logic [VW-1:0] set_tap(input logic [VW-1:0] v, input int k,
                                            input logic [NB-1:0] val);
    logic [VW-1:0] r;
    r = v;
    r[k*NB +: NB] = val;
    return r;
  endfunction

  function automatic logic [NB-1:0] tap(input int k);
    return o_coeff_flat[k*NB +: NB];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic update(input logic [VW-1:0] v);
    i_new_coeff = v;
    i_update_en = 1'b1;
    step();
    i_update_en = 1'b0;
  endtask

  task automatic host_read(input logic [NB_ADDR-1:0] a, input logic [NB-1:0] exp);
    i_host_addr = a;
    i_host_rd   = 1'b1;
    exp_q.push_back(exp);
    step();
    i_host_rd = 1'b0;
  endtask

  task automatic host_write(input logic [NB_ADDR-1:0] a, input logic [NB-1:0] d);
    i_host_addr  = a;
    i_host_wdata = d;
    i_host_wr    = 1'b1;
    step();
    i_host_wr = 1'b0;
  endtask

  task automatic reinit(input logic frz);
    i_freeze = frz;
    i_reinit = 1'b1;
    step();
    i_reinit = 1'b0;
  endtask

  // ---------------- read monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (o_host_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL host_rd_unexpected: got rvalid rdata=%h expected no rvalid", o_host_rdata);
      end else begin
        logic [NB-1:0] e;
        e = exp_q.pop_front();
        if (o_host_rdata !== e) begin
          errors++;
          $display("FAIL host_rdata: got %h expected %h", o_host_rdata, e);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [VW-1:0] init_v;
  logic [VW-1:0] m;
  logic [VW-1:0] v;
  logic [VW-1:0] sat_hi;
  logic [VW-1:0] sat_lo;

  initial begin
    init_v = '0;
    init_v[10*NB +: NB] = 8'h40;
    sat_hi = set_tap(init_v, 0, 8'h7F);
    sat_lo = set_tap(init_v, 20, 8'h80);

    i_reset = 1'b1; i_enable = 1'b1; i_new_coeff = '0; i_update_en = 1'b0;
    i_freeze = 1'b0; i_reinit = 1'b0; i_host_wr = 1'b0; i_host_rd = 1'b0;
    i_host_addr = '0; i_host_wdata = '0;
    repeat (3) step();

    // Reset values
    check_vec("reset_coeff", o_coeff_flat, init_v);
    check("reset_state", 32'(o_state), 32'd0);
    check("reset_count", o_update_count, 32'd0);
    check("reset_div", 32'(o_diverged), 32'd0);
    check("reset_rvalid", 32'(o_host_rvalid), 32'd0);
    i_reset = 1'b0;
    step();

    // Accepted update in RUN
    m = set_tap(init_v, 3, 8'h12);
    update(m);
    check("upd_tap3", 32'(tap(3)), 32'h12);
    check("upd_count", o_update_count, 32'd1);

    // Freeze blocks update and moves to HOLD
    i_freeze = 1'b1;
    update(set_tap(m, 3, 8'h55));
    check_vec("frz_coeff", o_coeff_flat, m);
    check("frz_state", 32'(o_state), 32'd1);
    check("frz_count", o_update_count, 32'd1);
    i_freeze = 1'b0;
    step();
    check("unfrz_state", 32'(o_state), 32'd0);

    // Host write collides with update: host wins on tap 5 only
    v = set_tap(set_tap(m, 5, 8'h11), 6, 8'h22);
    i_host_addr = 5'd5; i_host_wdata = 8'h33; i_host_wr = 1'b1;
    update(v);
    i_host_wr = 1'b0;
    m = set_tap(v, 5, 8'h33);
    check("hw_tap5", 32'(tap(5)), 32'h33);
    check("hw_tap6", 32'(tap(6)), 32'h22);
    check("hw_count", o_update_count, 32'd2);
    host_read(5'd5, 8'h33);
    host_read(5'd25, 8'h00);

    // Read and write of the same tap in one cycle returns the old value
    i_host_wr = 1'b1; i_host_wdata = 8'h44;
    host_read(5'd6, 8'h22);
    i_host_wr = 1'b0;
    m = set_tap(m, 6, 8'h44);
    host_read(5'd6, 8'h44);

    // Out-of-range write is ignored
    host_write(5'd21, 8'h5A);
    check_vec("hw_oor", o_coeff_flat, m);

    // Host write concurrent with reinit is dropped
    i_host_addr = 5'd2; i_host_wdata = 8'h77; i_host_wr = 1'b1;
    reinit(1'b0);
    i_host_wr = 1'b0;
    check_vec("reinit_coeff", o_coeff_flat, init_v);
    check("reinit_count", o_update_count, 32'd0);

    // Divergence after SAT_LIMIT consecutive rail updates
    for (int i = 0; i < 15; i++) update(sat_hi);
    check("sat15_tap0", 32'(tap(0)), 32'h7F);
    check("sat15_count", o_update_count, 32'd15);
    check("sat15_div", 32'(o_diverged), 32'd0);
    update(sat_hi);
    check_vec("div_coeff", o_coeff_flat, init_v);
    check("div_flag", 32'(o_diverged), 32'd1);
    check("div_state", 32'(o_state), 32'd2);
    check("div_count", o_update_count, 32'd15);
    update(set_tap(init_v, 4, 8'h09));
    i_freeze = 1'b1;
    step();
    i_freeze = 1'b0;
    step();
    check_vec("div_ignore_coeff", o_coeff_flat, init_v);
    check("div_ignore_state", 32'(o_state), 32'd2);
    check("div_ignore_count", o_update_count, 32'd15);

    // Reinit leaves DIVERGED
    reinit(1'b0);
    check_vec("rein_coeff", o_coeff_flat, init_v);
    check("rein_div", 32'(o_diverged), 32'd0);
    check("rein_count", o_update_count, 32'd0);
    check("rein_state", 32'(o_state), 32'd0);

    // Clean update in between resets the run; min rail also counts
    for (int i = 0; i < 15; i++) update(sat_hi);
    update(set_tap(init_v, 1, 8'h7E));
    for (int i = 0; i < 15; i++) update(sat_lo);
    check("run_count31", o_update_count, 32'd31);
    check("run_nodiv", 32'(o_diverged), 32'd0);
    check("run_state", 32'(o_state), 32'd0);
    check("run_tap20", 32'(tap(20)), 32'h80);
    check("run_tap0", 32'(tap(0)), 32'h00);
    update(sat_lo);
    check("min_div_flag", 32'(o_diverged), 32'd1);
    check("min_div_count", o_update_count, 32'd31);

    // Reinit with freeze held lands in HOLD
    reinit(1'b1);
    check("rein_hold_state", 32'(o_state), 32'd1);
    check("rein_hold_count", o_update_count, 32'd0);
    i_freeze = 1'b0;
    step();
    check("rein_run_state", 32'(o_state), 32'd0);

    // Reset mid-stream of updates, with a read in the same cycle
    update(set_tap(init_v, 7, 8'h21));
    update(set_tap(init_v, 7, 8'h22));
    check("pre_rst_count", o_update_count, 32'd2);
    i_new_coeff = set_tap(init_v, 7, 8'h23);
    i_update_en = 1'b1; i_host_rd = 1'b1; i_host_addr = 5'd7; i_reset = 1'b1;
    step();
    i_update_en = 1'b0; i_host_rd = 1'b0; i_reset = 1'b0;
    check_vec("rst_mid_coeff", o_coeff_flat, init_v);
    check("rst_mid_count", o_update_count, 32'd0);
    check("rst_mid_state", 32'(o_state), 32'd0);
    check("rst_mid_rvalid", 32'(o_host_rvalid), 32'd0);
    host_read(5'd10, 8'h40);

    repeat (3) step();
    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ffe_coeff_bank.md
Name: ffe_coeff_bank

Overview:
- Coefficient storage stage directly downstream of the adaptation engine.
- Registers the FFE_LEN tap vector. Accepts the engine's o_new_coeff/o_update_en as write data and enable. Drives the current vector back to the FIR and to the adaptation engine's coeff_flat input.
- Adds freeze control, a host single-tap read/write port, a saturation-based divergence guard, and an update counter.

Parameters:
- FFE_LEN, 21, number of taps
- NB, 8, coefficient width (signed, two's complement)
- NBF, 7, coefficient fractional bits (informational)
- NB_ADDR, 5, host tap address width; must be at least clog2(FFE_LEN)
- CENTER_TAP, 10, index of the initialised main tap
- INIT_CENTER, 64, initial main-tap code (0.5 at NBF=7)
- SAT_LIMIT, 16, consecutive saturated updates that declare divergence

Ports:
- i_clock  in  1  single clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  global enable; when low, adaptation writes are blocked
- i_new_coeff  in  FFE_LEN*NB  proposed vector; tap k is bits [k*NB +: NB]
- i_update_en  in  1  write strobe for i_new_coeff
- i_freeze  in  1  level; holds coefficients against adaptation
- i_reinit  in  1  pulse; reloads the init vector and clears status
- i_host_wr  in  1  host tap write strobe
- i_host_rd  in  1  host tap read strobe
- i_host_addr  in  NB_ADDR  host tap index
- i_host_wdata  in  NB  host write data
- o_host_rdata  out  NB  registered read data
- o_host_rvalid  out  1  one-cycle pulse, qualifies o_host_rdata
- o_coeff_flat  out  FFE_LEN*NB  current coefficient vector (register output)
- o_state  out  2  00 RUN, 01 HOLD, 10 DIVERGED
- o_diverged  out  1  sticky divergence flag
- o_update_count  out  32  accepted adaptation updates, saturating

Behaviour:
- Init vector: tap CENTER_TAP = INIT_CENTER; all other taps = 0.
- Reset values:
  - o_coeff_flat = init vector; o_state = RUN.
  - o_diverged, o_update_count, o_host_rdata, o_host_rvalid and the internal sat_cnt are all 0.
- Priority at each edge: i_reset > i_reinit > host write > adaptation update.
- Accepted update: state RUN, i_enable = 1, i_update_en = 1 and i_freeze = 0.
  - The vector appears on o_coeff_flat at the next edge (1-cycle latency).
  - o_update_count increments and saturates at 0xFFFFFFFF.
- Saturation tracking, evaluated only on accepted updates:
  - If any tap of i_new_coeff equals the max code (2^(NB-1)-1) or the min code (-2^(NB-1)), sat_cnt increments; otherwise sat_cnt is cleared.
  - Cycles with no accepted update leave sat_cnt unchanged.
- Divergence: when an accepted update would make sat_cnt equal SAT_LIMIT:
  - that update is discarded and o_coeff_flat loads the init vector;
  - o_diverged is set to 1 and the state moves to DIVERGED;
  - o_update_count does not increment.
- FSM transitions:
  - RUN to HOLD when i_freeze = 1; HOLD to RUN when i_freeze = 0.
  - In HOLD, sat_cnt is retained.
  - DIVERGED ignores all adaptation updates and i_freeze; it is left only by i_reinit or i_reset.
- i_reinit, in any state:
  - loads the init vector;
  - clears sat_cnt, o_update_count and o_diverged;
  - next state is HOLD if i_freeze = 1, otherwise RUN.
- Host write:
  - Legal in any state; tap i_host_addr loads i_host_wdata at the next edge.
  - If it coincides with an accepted update, the host value wins for that tap only; all other taps take i_new_coeff.
  - Addresses >= FFE_LEN are ignored.
  - A host write concurrent with i_reinit is dropped.
- Host read:
  - o_host_rdata returns the tap value as it was before the same edge's update, registered with 1-cycle latency; o_host_rvalid pulses for that cycle.
  - Addresses >= FFE_LEN return 0 with rvalid still asserted.
  - rd and wr may be asserted in the same cycle; the read returns the old value.
- Reset mid-operation: state, count and flags return to reset values at the same edge; an in-flight read pulse is cancelled.
- No arithmetic on coefficient data: pure storage; the counter is the only adder.

Decomposition:
- Shared package (ffe_pkg):
  - FFE_LEN, NB, NBF;
  - the state encoding constants ST_RUN, ST_HOLD, ST_DIV;
  - the coeff-max/min code constants.
- One sub-module, coeff_sat_detect: combinational "any tap at rail" reduction over the flat vector, reusable by the adaptation engine's monitors.
- FSM, counters and the register bank stay in ffe_coeff_bank.

Test Plan:
- Reset -> o_coeff_flat tap10 = 0x40, all other taps 0x00; o_state = 00; count = 0.
- RUN, i_update_en with tap3 = 0x12 for 1 cycle -> next cycle tap3 = 0x12; count = 1. With i_freeze = 1, same stimulus -> o_coeff_flat unchanged, o_state = 01, count unchanged.
- Host write addr 5 = 0x33 in the same cycle as an update carrying tap5 = 0x11 and tap6 = 0x22 -> tap5 = 0x33, tap6 = 0x22. Host read addr 5 the next cycle -> rvalid pulse with rdata = 0x33. Read of addr 25 -> rdata = 0x00.
- 16 consecutive accepted updates with tap0 = 0x7F (SAT_LIMIT = 16):
  - after the 15th, tap0 = 0x7F and count = 15;
  - the 16th produces the init vector, o_diverged = 1, o_state = 10;
  - later updates are ignored.
- 15 saturated updates, then 1 clean update, then 15 more saturated -> no divergence; count = 31.
- DIVERGED, then i_reinit pulse with i_freeze = 0 -> init vector, o_diverged = 0, count = 0, o_state = 00. Assert i_reset mid-stream of updates -> reset values on the next cycle.
